// File: rtl/delay_sample_reader_pkg.sv
// -----------------------------------------------------------------------------
// delay_sample_reader_pkg
// Shared definitions for the delay-line measurement readers:
//   state_t          - reader FSM states
//   TIMEOUT_DEFAULT  - default wait budget (cycles) for ld_reg / fin
//   cntWidth()       - width of a single tap count for a TAP_W-tap line
//   sumWidth()       - width of an exact sum of 2^samplesLog2 tap counts
// -----------------------------------------------------------------------------
package delay_sample_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      WAIT_LD,
      WAIT_FIN,
      ENCODE,
      ACCUM,
      PRESENT
   } state_t;

   localparam int TIMEOUT_DEFAULT = 1024;

   // A tap count ranges over 0..tapW inclusive, hence the +1.
   function automatic int cntWidth(input int tapW);
      return $clog2(tapW + 1);
   endfunction

   // Summing 2^samplesLog2 counts needs samplesLog2 extra bits to never wrap.
   function automatic int sumWidth(input int tapW, input int samplesLog2);
      return cntWidth(tapW) + samplesLog2;
   endfunction

endpackage

// File: rtl/delay_sample_reader_therm_encode.sv
// -----------------------------------------------------------------------------
// therm_encode
// Combinational thermometer decoder for a tapped delay line.
// Ports:
//   taps   in  TAP_W  snapshot, bit 0 nearest the launch point
//   count  out CNT_W  number of set taps (popcount)
//   bubble out 1      snapshot is not a clean 0..01..1 thermometer code
// -----------------------------------------------------------------------------
module therm_encode #(
   parameter int TAP_W = 64,
   parameter int CNT_W = 7
) (
   input  logic [TAP_W-1:0] taps,
   output logic [CNT_W-1:0] count,
   output logic             bubble
);

   always_comb begin
      count = '0;
      for (int i = 0; i < TAP_W; i++) begin
         count = count + CNT_W'(taps[i]);
      end
   end

   // A clean code is 2^k-1; adding one then clears every set bit, so any
   // surviving overlap means a 1 sits above a 0.
   assign bubble = |(taps & (taps + TAP_W'(1)));

endmodule

// File: rtl/delay_sample_reader.sv
// -----------------------------------------------------------------------------
// delay_sample_reader
// Re-arms the high-to-low path measurement controller, snapshots the delay
// line on ld_reg, waits for fin, then accumulates 2^SAMPLES_LOG2 tap counts
// and offers the batch result on a valid/ready port.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             single-cycle batch request (honoured only in IDLE)
//   ld_reg, fin       controller load strobe / finished flag
//   taps              delay-line snapshot
//   restart           holds the controller in its initial state while high
//   busy              batch in progress (state != IDLE)
//   res_valid/ready   result handshake
//   res_sum/max/bubbles/err  batch result
//   dbgState          current FSM state
//
// Handshake: res_valid rises with the result and stays high, with every res_*
// output frozen, until a cycle in which res_ready is high; that cycle is the
// transfer and res_valid drops on the following edge.
// -----------------------------------------------------------------------------
module delay_sample_reader
   import delay_sample_reader_pkg::*;
#(
   parameter  int TAP_W        = 64,
   parameter  int SAMPLES_LOG2 = 4,
   parameter  int RESTART_CYC  = 2,
   parameter  int TIMEOUT      = TIMEOUT_DEFAULT,
   localparam int CNT_W        = cntWidth(TAP_W),
   localparam int SUM_W        = sumWidth(TAP_W, SAMPLES_LOG2),
   localparam int BUB_W        = SAMPLES_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ld_reg,
   input  logic             fin,
   input  logic [TAP_W-1:0] taps,
   output logic             restart,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SUM_W-1:0] res_sum,
   output logic [CNT_W-1:0] res_max,
   output logic [BUB_W-1:0] res_bubbles,
   output logic             res_err,
   output state_t           dbgState
);

   localparam int HOLD_W = (RESTART_CYC > 1) ? $clog2(RESTART_CYC) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t                  state;
   logic [TAP_W-1:0]        snapshot;
   logic [CNT_W-1:0]        encCount;
   logic                    encBubble;
   logic [CNT_W-1:0]        count;
   logic                    bubble;
   logic [HOLD_W-1:0]       holdCnt;
   logic [WAIT_W-1:0]       waitCnt;
   logic [SAMPLES_LOG2-1:0] index;

   therm_encode #(
      .TAP_W (TAP_W),
      .CNT_W (CNT_W)
   ) u_encode (
      .taps   (snapshot),
      .count  (encCount),
      .bubble (encBubble)
   );

   assign dbgState = state;

   // The accumulators double as the result registers; they are only written
   // while a batch runs, so they are naturally frozen in PRESENT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         restart     <= 1'b1;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_err     <= 1'b0;
         res_sum     <= '0;
         res_max     <= '0;
         res_bubbles <= '0;
         snapshot    <= '0;
         count       <= '0;
         bubble      <= 1'b0;
         holdCnt     <= '0;
         waitCnt     <= '0;
         index       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  res_sum     <= '0;
                  res_max     <= '0;
                  res_bubbles <= '0;
                  res_err     <= 1'b0;
                  index       <= '0;
                  holdCnt     <= '0;
                  busy        <= 1'b1;
                  state       <= HOLD;
               end
            end

            HOLD: begin
               if (holdCnt == HOLD_W'(RESTART_CYC - 1)) begin
                  restart <= 1'b0;
                  waitCnt <= '0;
                  state   <= WAIT_LD;
               end else begin
                  holdCnt <= holdCnt + 1'b1;
               end
            end

            // ld_reg wins over a timeout landing in the same cycle.
            WAIT_LD: begin
               if (ld_reg) begin
                  snapshot <= taps;
                  waitCnt  <= '0;
                  state    <= WAIT_FIN;
               end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  restart   <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end

            // Further ld_reg pulses are ignored here: the snapshot is kept.
            WAIT_FIN: begin
               if (fin) begin
                  state <= ENCODE;
               end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  restart   <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end

            ENCODE: begin
               count  <= encCount;
               bubble <= encBubble;
               state  <= ACCUM;
            end

            ACCUM: begin
               res_sum     <= res_sum + SUM_W'(count);
               res_bubbles <= res_bubbles + BUB_W'(bubble);
               if (count > res_max) begin
                  res_max <= count;
               end
               restart <= 1'b1;
               if (index == {SAMPLES_LOG2{1'b1}}) begin
                  res_valid <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  index   <= index + 1'b1;
                  holdCnt <= '0;
                  state   <= HOLD;
               end
            end

            PRESENT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_sample_reader.sv
// -----------------------------------------------------------------------------
// tb_delay_sample_reader
// Directed bench: a small controller driver answers restart with ld_reg/fin,
// batch results are compared against hand-computed values held in exp_q.
// -----------------------------------------------------------------------------
module tb_delay_sample_reader;
   import delay_sample_reader_pkg::*;

   localparam int TAP_W        = 64;
   localparam int SAMPLES_LOG2 = 4;
   localparam int RESTART_CYC  = 2;
   localparam int TIMEOUT      = 1024;
   localparam int CNT_W        = 7;
   localparam int SUM_W        = 11;
   localparam int BUB_W        = 5;
   localparam int RES_W        = 1 + BUB_W + CNT_W + SUM_W;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             ld_reg = 1'b0;
   logic             fin = 1'b0;
   logic [TAP_W-1:0] taps = '0;
   logic             res_ready = 1'b0;
   logic             restart;
   logic             busy;
   logic             res_valid;
   logic [SUM_W-1:0] res_sum;
   logic [CNT_W-1:0] res_max;
   logic [BUB_W-1:0] res_bubbles;
   logic             res_err;
   state_t           dbgState;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   delay_sample_reader #(
      .TAP_W        (TAP_W),
      .SAMPLES_LOG2 (SAMPLES_LOG2),
      .RESTART_CYC  (RESTART_CYC),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .ld_reg      (ld_reg),
      .fin         (fin),
      .taps        (taps),
      .restart     (restart),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_sum     (res_sum),
      .res_max     (res_max),
      .res_bubbles (res_bubbles),
      .res_err     (res_err),
      .dbgState    (dbgState)
   );

   // ---------------- scoreboard ----------------
   int nChecks = 0;
   int nPass   = 0;
   logic [RES_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [RES_W-1:0] packRes(input int sum, input int mx, input int bub, input bit err);
      return {err, BUB_W'(bub), CNT_W'(mx), SUM_W'(sum)};
   endfunction

   task automatic checkResult(input string tag);
      logic [RES_W-1:0] e;
      e = exp_q.pop_front();
      check({tag, "_valid"},   64'(res_valid),   64'(1));
      check({tag, "_sum"},     64'(res_sum),     64'(e[SUM_W-1:0]));
      check({tag, "_max"},     64'(res_max),     64'(e[SUM_W +: CNT_W]));
      check({tag, "_bubbles"}, 64'(res_bubbles), 64'(e[SUM_W+CNT_W +: BUB_W]));
      check({tag, "_err"},     64'(res_err),     64'(e[RES_W-1]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic waitRestart(input logic lvl);
      int n = 0;
      while (restart !== lvl && n < 200) begin
         tick();
         n++;
      end
      if (restart !== lvl) check("wait_restart", 64'(restart), 64'(lvl));
   endtask

   task automatic waitValid();
      int n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // restart must fall RESTART_CYC edges after the edge that takes start.
   task automatic startBatch();
      logic [2:0] seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 64'(busy), 64'(1));
      seen[2] = restart;
      tick();
      seen[1] = restart;
      tick();
      seen[0] = restart;
      check("start_restart_fall", 64'(seen), 64'(3'b110));
   endtask

   // mode 0: ld then fin; mode 1: extra ld pulse with other data before fin;
   // mode 2: ld and fin in the same cycle, fin held.
   task automatic doSample(input logic [TAP_W-1:0] value, input int mode);
      waitRestart(1'b0);
      tick();
      ld_reg = 1'b1;
      taps   = value;
      if (mode == 2) fin = 1'b1;
      tick();
      ld_reg = 1'b0;
      taps   = ~value;
      if (mode == 1) begin
         tick();
         ld_reg = 1'b1;
         tick();
         ld_reg = 1'b0;
      end
      fin = 1'b1;
      waitRestart(1'b1);
      fin = 1'b0;
   endtask

   task automatic accept();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [RES_W-1:0] held;

      repeat (3) tick();
      check("rst_state",   64'(dbgState),    64'(IDLE));
      check("rst_restart", 64'(restart),     64'(1));
      check("rst_busy",    64'(busy),        64'(0));
      check("rst_valid",   64'(res_valid),   64'(0));
      check("rst_err",     64'(res_err),     64'(0));
      check("rst_sum",     64'(res_sum),     64'(0));
      check("rst_max",     64'(res_max),     64'(0));
      check("rst_bubbles", 64'(res_bubbles), 64'(0));
      rst_n = 1'b1;
      tick();

      // Clean codes: 16 x popcount 16.
      exp_q.push_back(packRes(256, 16, 0, 1'b0));
      startBatch();
      for (int i = 0; i < 16; i++) doSample(64'h0000_0000_0000_FFFF, 0);
      waitValid();
      checkResult("clean");

      // Result held with res_ready low for 20 cycles.
      held = {res_err, res_bubbles, res_max, res_sum};
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_valid", 64'(res_valid), 64'(1));
         check("hold_res",   64'({res_err, res_bubbles, res_max, res_sum}), 64'(packRes(256, 16, 0, 1'b0)));
      end
      check("hold_snapshot", 64'(held), 64'(packRes(256, 16, 0, 1'b0)));

      // start in the accept cycle is ignored.
      res_ready = 1'b1;
      start     = 1'b1;
      tick();
      res_ready = 1'b0;
      start     = 1'b0;
      check("accept_valid", 64'(res_valid), 64'(0));
      check("accept_busy",  64'(busy),      64'(0));
      check("accept_state", 64'(dbgState),  64'(IDLE));
      tick();
      check("ignored_start_state", 64'(dbgState), 64'(IDLE));

      // Mixed: 0, 64, then 14 x 10 -> 204 / 64. Exercises the re-latch
      // guard and simultaneous ld_reg/fin.
      exp_q.push_back(packRes(204, 64, 0, 1'b0));
      startBatch();
      doSample(64'h0, 0);
      doSample(64'hFFFF_FFFF_FFFF_FFFF, 1);
      for (int i = 0; i < 14; i++) doSample(64'h3FF, (i == 3) ? 2 : ((i == 7) ? 1 : 0));
      waitValid();
      checkResult("mixed");
      accept();

      // Bubbles: 0xF7 (count 7) on samples 1, 5, 9; 0xFFFF elsewhere.
      exp_q.push_back(packRes(3 * 7 + 13 * 16, 16, 3, 1'b0));
      startBatch();
      for (int i = 0; i < 16; i++)
         doSample((i == 1 || i == 5 || i == 9) ? 64'hF7 : 64'hFFFF, 0);
      waitValid();
      checkResult("bubble");
      accept();

      // Timeout: counts 1..5 then ld_reg never arrives.
      exp_q.push_back(packRes(15, 5, 0, 1'b1));
      startBatch();
      doSample(64'h01, 0);
      doSample(64'h03, 0);
      doSample(64'h07, 0);
      doSample(64'h0F, 0);
      doSample(64'h1F, 0);
      waitRestart(1'b0);
      repeat (TIMEOUT - 1) tick();
      check("timeout_early_err",   64'(res_err),   64'(0));
      check("timeout_early_valid", 64'(res_valid), 64'(0));
      tick();
      checkResult("timeout");
      check("timeout_restart", 64'(restart), 64'(1));
      accept();

      // Reset while waiting for fin.
      startBatch();
      doSample(64'hFFFF, 0);
      waitRestart(1'b0);
      tick();
      ld_reg = 1'b1;
      taps   = 64'hFF;
      tick();
      ld_reg = 1'b0;
      check("pre_rst_state", 64'(dbgState), 64'(WAIT_FIN));
      check("pre_rst_sum",   64'(res_sum),  64'(16));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_state",   64'(dbgState),    64'(IDLE));
      check("midrst_restart", 64'(restart),     64'(1));
      check("midrst_valid",   64'(res_valid),   64'(0));
      check("midrst_busy",    64'(busy),        64'(0));
      check("midrst_sum",     64'(res_sum),     64'(0));
      check("midrst_max",     64'(res_max),     64'(0));
      check("midrst_bubbles", 64'(res_bubbles), 64'(0));
      tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/delay_sample_reader.md
# delay_sample_reader

Reader-side companion to the high-to-low path measurement controller. It re-arms the controller, snapshots the tapped delay line when the controller raises `ld_reg`, and waits for `fin`. It then converts the thermometer snapshot to a tap count, accumulates a batch of 2^SAMPLES_LOG2 measurements, and presents the batch result on a valid/ready port to the host-side logic.

## Interface
- TAP_W, 64, delay-line tap count (snapshot width)
- SAMPLES_LOG2, 4, log2 of measurements per batch (16)
- RESTART_CYC, 2, cycles `restart` is held per re-arm (≥1)
- TIMEOUT, 1024, max cycles waiting for `ld_reg` or `fin` before abort
- Derived: CNT_W = clog2(TAP_W+1); SUM_W = CNT_W+SAMPLES_LOG2

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle batch request
- ld_reg  in  1  controller's load strobe
- fin  in  1  controller's finished flag
- taps  in  TAP_W  delay-line snapshot, bit 0 nearest launch point
- restart  out  1  holds the controller in its initial state while high
- busy  out  1  batch in progress
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  SUM_W  sum of tap counts over the batch
- res_max  out  CNT_W  largest single tap count in the batch
- res_bubbles  out  SAMPLES_LOG2+1  snapshots that were not clean thermometer codes
- res_err  out  1  batch aborted by timeout

## Operation
- States: IDLE, HOLD, WAIT_LD, WAIT_FIN, ENCODE, ACCUM, PRESENT.
- IDLE: `restart`=1. `start` clears sum, max, bubbles, err, and sample index, then goes to HOLD.
- HOLD: `restart`=1 for RESTART_CYC cycles, then WAIT_LD.
- WAIT_LD: `restart`=0. On the first cycle `ld_reg`=1, latch `taps` into the snapshot register and go to WAIT_FIN.
- WAIT_FIN: on `fin`=1, go to ENCODE. A second `ld_reg` pulse before `fin` does not re-latch.
- ENCODE: count = popcount(snapshot), registered. bubble = snapshot has any 1 above a 0.
- ACCUM:
  - sum += count; max = max(max, count); bubbles += bubble.
  - If index = 2^SAMPLES_LOG2−1, go to PRESENT; else index++ and go to HOLD.
- Timeout: one shared wait counter, cleared on entry to WAIT_LD and to WAIT_FIN. When it reaches TIMEOUT−1, set err=1 and go to PRESENT with the partial accumulators.
- PRESENT:
  - `res_valid`=1, `restart`=1, and `res_*` held stable until `res_ready`=1.
  - On the handshake, go to IDLE.
- `start` outside IDLE is ignored, including in the handshake cycle.
- Accumulator widths are exact. Full-scale count TAP_W × 2^SAMPLES_LOG2 must not wrap.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `restart`=1; `busy`, `res_valid`, `res_err`=0; `res_sum`, `res_max`, `res_bubbles`=0; state IDLE.
- `rst_n` low mid-batch aborts at the next edge with no result. `restart` stays asserted.
- All outputs are registered.
- `start` to `restart` falling edge: 1+RESTART_CYC cycles.
- `ld_reg` sampled in cycle t: snapshot equals `taps` at cycle t.
- `fin` seen in cycle t: accumulators updated at end of cycle t+2.
- Per-sample overhead excluding controller wait: RESTART_CYC+3 cycles.
- Simultaneous `ld_reg` and `fin` in WAIT_LD: latch the snapshot, then honor `fin` on the following cycle if it is still high. The controller holds `fin` high.

## Structure
- Shared package: state enum, CNT_W/SUM_W derivation function, and TIMEOUT default. The measurement controller's users share it.
- One sub-module, `therm_encode`: combinational popcount plus bubble detect over TAP_W, reused by other delay-line readers.

## Test plan
- Clean codes: TAP_W=64, 16 samples, snapshot 0x0000_0000_0000_FFFF every time → res_sum=256, res_max=16, res_bubbles=0, res_err=0.
- Mixed: counts 0, 64, then 10 for the remaining 14 samples → res_sum=204, res_max=64.
- Bubbles: snapshot 0x...00F7 on 3 samples, clean on the rest → res_bubbles=3; each bubble sample contributes count 7.
- Timeout: `ld_reg` never asserted after sample 5 → res_err=1 exactly TIMEOUT cycles after entering WAIT_LD; res_sum holds samples 0–4 only.
- Handshake: `res_ready` low for 20 cycles → outputs stable throughout. `start` in the accept cycle is ignored; `start` one cycle later begins a new batch.
- Reset mid-WAIT_FIN → next cycle: state IDLE, `restart`=1, `res_valid`=0, accumulators 0.
